ws2812_rx: RTL and testbench

- Single-wire WS2812/SK6812 decoder; the receive-side counterpart of the LED chain driver.
- Samples a serial LED data line and measures each high pulse to recover bits.
- Assembles 24-bit GRB pixels and presents them with a pixel index.
- Detects the latch/reset gap as end-of-frame. Used for chain loopback checking and for accepting LED streams from an external controller.

---
 rtl/ws2812_rx.sv | 222 ++++++++++++++++++++++
 tb/tb_ws2812_rx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_rx.sv
// WS2812/SK6812 single-wire receiver: measures each high pulse on DI, rebuilds
// 24-bit GRB pixels, and flags the long low gap as end-of-frame.
module ws2812_rx #(
  parameter int NUM_LEDS     = 4,
  parameter int SYSTEM_CLOCK = 50_000_000
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        DI,
  output logic                        pixel_valid,
  output logic [$clog2(NUM_LEDS)-1:0] address,
  output logic [7:0]                  red,
  output logic [7:0]                  green,
  output logic [7:0]                  blue,
  output logic                        frame_done,
  output logic                        bit_error,
  output logic                        overflow,
  output logic                        in_frame
);

  localparam int CYCLE_COUNT  = SYSTEM_CLOCK / 800_000;
  localparam int THRESH       = 3 * CYCLE_COUNT / 8;
  localparam int MIN_HIGH     = CYCLE_COUNT / 16;
  localparam int MAX_HIGH     = 2 * CYCLE_COUNT;
  localparam int RESET_DETECT = 40 * CYCLE_COUNT;

  localparam int AW = $clog2(NUM_LEDS);
  localparam int PW = $clog2(NUM_LEDS + 1);
  localparam int LW = $clog2(RESET_DETECT) + 1;

  localparam logic [7:0]    C_THRESH   = 8'(THRESH);
  localparam logic [7:0]    C_MIN_HIGH = 8'(MIN_HIGH);
  localparam logic [7:0]    C_MAX_HIGH = 8'(MAX_HIGH);
  localparam logic [LW-1:0] C_LO_END   = LW'(RESET_DETECT - 1);
  localparam logic [PW-1:0] C_NUM_LEDS = PW'(NUM_LEDS);

  typedef enum logic [1:0] {
    S_SYNC,
    S_LOW,
    S_HIGH
  } state_t;

  state_t        r_state, w_state_nx;
  logic          r_di_meta, r_di_s, r_di_prev;
  logic [7:0]    r_hi_cnt, w_hi_nx;
  logic [LW-1:0] r_lo_cnt, w_lo_nx;
  logic [4:0]    r_bit_cnt;
  logic [PW-1:0] r_pix_cnt;
  logic [23:0]   r_shift;
  logic          r_pix_pend;

  logic w_rise, w_fall;
  logic w_shift, w_bit, w_start, w_frame_end;
  logic w_short_err, w_long_err, w_sync_exit;
  logic [7:0]    w_hi_inc;
  logic [LW-1:0] w_lo_inc;

  assign w_rise   = r_di_s & ~r_di_prev;
  assign w_fall   = ~r_di_s & r_di_prev;
  assign w_hi_inc = (r_hi_cnt == '1) ? r_hi_cnt : r_hi_cnt + 8'd1;
  assign w_lo_inc = (r_lo_cnt == '1) ? r_lo_cnt : r_lo_cnt + LW'(1);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, which is what makes the chain a real
  // two-stage synchroniser rather than one wire.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_di_meta <= 1'b0;
      r_di_s    <= 1'b0;
      r_di_prev <= 1'b0;
      r_state   <= S_SYNC;
      r_hi_cnt  <= '0;
      r_lo_cnt  <= '0;
    end else begin
      r_di_meta <= DI;
      r_di_s    <= r_di_meta;
      r_di_prev <= r_di_s;
      r_state   <= w_state_nx;
      r_hi_cnt  <= w_hi_nx;
      r_lo_cnt  <= w_lo_nx;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    w_state_nx  = r_state;
    w_hi_nx     = r_hi_cnt;
    w_lo_nx     = r_lo_cnt;
    w_shift     = 1'b0;
    w_bit       = 1'b0;
    w_start     = 1'b0;
    w_frame_end = 1'b0;
    w_short_err = 1'b0;
    w_long_err  = 1'b0;
    w_sync_exit = 1'b0;
    unique case (r_state)
      S_SYNC: begin
        if (r_di_s) begin
          w_lo_nx = '0;
        end else if (r_lo_cnt >= C_LO_END) begin
          w_state_nx  = S_LOW;
          w_sync_exit = 1'b1;
        end else begin
          w_lo_nx = w_lo_inc;
        end
      end
      S_LOW: begin
        if (w_rise) begin
          w_state_nx = S_HIGH;
          w_hi_nx    = 8'd1;
          w_lo_nx    = '0;
          w_start    = 1'b1;
        end else begin
          w_lo_nx     = w_lo_inc;
          w_frame_end = in_frame && (r_lo_cnt == C_LO_END);
        end
      end
      S_HIGH: begin
        if (r_hi_cnt >= C_MAX_HIGH) begin
          w_state_nx = S_SYNC;
          w_lo_nx    = '0;
          w_long_err = 1'b1;
        end else if (w_fall) begin
          if (r_hi_cnt < C_MIN_HIGH) begin
            w_state_nx  = S_SYNC;
            w_lo_nx     = '0;
            w_short_err = 1'b1;
          end else begin
            w_state_nx = S_LOW;
            w_lo_nx    = LW'(1);
            w_shift    = 1'b1;
            w_bit      = (r_hi_cnt >= C_THRESH);
          end
        end else begin
          w_hi_nx = w_hi_inc;
        end
      end
      default: begin
        w_state_nx = S_SYNC;
        w_lo_nx    = '0;
      end
    endcase
  end

  // Later assignments in this block take priority: frame end and resync
  // bookkeeping override the pixel path in the (impossible) case they coincide.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pixel_valid <= 1'b0;
      address     <= '0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      frame_done  <= 1'b0;
      bit_error   <= 1'b0;
      overflow    <= 1'b0;
      in_frame    <= 1'b0;
      r_bit_cnt   <= '0;
      r_pix_cnt   <= '0;
      r_shift     <= '0;
      r_pix_pend  <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      bit_error   <= 1'b0;
      r_pix_pend  <= 1'b0;

      if (w_start) in_frame <= 1'b1;

      if (w_shift) begin
        r_shift <= {r_shift[22:0], w_bit};
        if (r_bit_cnt == 5'd23) begin
          r_bit_cnt  <= '0;
          r_pix_pend <= 1'b1;
        end else begin
          r_bit_cnt <= r_bit_cnt + 5'd1;
        end
      end

      if (r_pix_pend) begin
        if (r_pix_cnt < C_NUM_LEDS) begin
          green       <= r_shift[23:16];
          red         <= r_shift[15:8];
          blue        <= r_shift[7:0];
          address     <= r_pix_cnt[AW-1:0];
          pixel_valid <= 1'b1;
          r_pix_cnt   <= r_pix_cnt + PW'(1);
        end else begin
          overflow <= 1'b1;
        end
      end

      if (w_short_err) begin
        bit_error <= 1'b1;
        r_bit_cnt <= '0;
      end

      if (w_long_err) begin
        bit_error <= 1'b1;
        in_frame  <= 1'b0;
        r_bit_cnt <= '0;
        r_pix_cnt <= '0;
      end

      if (w_frame_end) begin
        frame_done <= (r_pix_cnt != '0);
        bit_error  <= (r_bit_cnt != '0);
      end

      // Leaving resync starts a clean frame without announcing the aborted one.
      if (w_frame_end || w_sync_exit) begin
        in_frame  <= 1'b0;
        r_bit_cnt <= '0;
        r_pix_cnt <= '0;
        address   <= '0;
        overflow  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ws2812_rx.sv
// Directed bench for ws2812_rx: drives DI with hand-shaped pulses and checks
// decoded pixels, frame/error strobes and overflow against fixed expectations.
module tb_ws2812_rx;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       DI;
  logic       pixel_valid;
  logic [1:0] address;
  logic [7:0] red, green, blue;
  logic       frame_done, bit_error, overflow, in_frame;

  ws2812_rx #(.NUM_LEDS(4), .SYSTEM_CLOCK(50_000_000)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .DI         (DI),
    .pixel_valid(pixel_valid),
    .address    (address),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .frame_done (frame_done),
    .bit_error  (bit_error),
    .overflow   (overflow),
    .in_frame   (in_frame)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: samples on the falling edge, away from the DUT's active edge.
  logic [25:0] pq[$];
  int n_done = 0;
  int n_err  = 0;
  int pv_cyc = 0;
  always @(negedge clk) begin
    if (pixel_valid) begin
      pq.push_back({address, green, red, blue});
      pv_cyc = cyc;
    end
    if (frame_done) n_done++;
    if (bit_error)  n_err++;
  end

  int n_checks = 0;
  int n_errors = 0;
  int last_fall = 0;
  int b_pix, b_done, b_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_pix  = pq.size();
    b_done = n_done;
    b_err  = n_err;
  endtask

  task automatic expect_pix(input string tag, input int idx, input logic [25:0] exp);
    int k;
    k = b_pix + idx;
    if (pq.size() > k) check(tag, 32'(pq[k]), 32'(exp));
    else               check({tag, "_missing"}, pq.size(), k + 1);
  endtask

  task automatic expect_counts(input string tag, input int pix, input int done, input int err);
    check({tag, "_pixels"}, pq.size() - b_pix, pix);
    check({tag, "_frame_done"}, n_done - b_done, done);
    check({tag, "_bit_error"}, n_err - b_err, err);
  endtask

  // Each stimulus task starts and ends 1 ns after a rising clock edge.
  task automatic idle(input int n);
    DI = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int hi, input int lo);
    DI = 1'b1;
    repeat (hi) @(posedge clk);
    #1;
    DI = 1'b0;
    last_fall = cyc;
    repeat (lo) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    if (b) pulse(42, 20);
    else   pulse(20, 42);
  endtask

  task automatic send_pixel(input logic [23:0] p);
    for (int i = 23; i >= 0; i--) send_bit(p[i]);
  endtask

  localparam int GAP = 2600;

  logic [23:0] px;
  logic [11:0] part;

  initial begin
    reset_n = 1'b0;
    DI      = 1'b0;
    #5;
    check("reset_outputs",
          {pixel_valid, address, red, green, blue, frame_done, bit_error, overflow, in_frame}, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle(GAP);

    // Single pixel with a long chain-driver style latch gap.
    snap();
    send_pixel(24'hA53C0F);
    check("single_in_frame", in_frame, 1);
    check("single_latency", pv_cyc - last_fall, 4);
    idle(100 * 62);
    expect_pix("single_pix", 0, {2'd0, 24'hA53C0F});
    expect_counts("single", 1, 1, 0);
    check("single_in_frame_end", in_frame, 0);
    check("single_addr_end", address, 0);

    // Four pixels back to back, then the next frame restarts at address 0.
    snap();
    for (int i = 0; i < 4; i++) begin
      px = {8'(i + 1), 8'(i + 2), 8'(i + 3)};
      send_pixel(px);
    end
    check("four_addr_hold", address, 3);
    idle(GAP);
    for (int i = 0; i < 4; i++) begin
      px = {8'(i + 1), 8'(i + 2), 8'(i + 3)};
      expect_pix("four_pix", i, {2'(i), px});
    end
    expect_counts("four", 4, 1, 0);
    snap();
    send_pixel(24'h112233);
    idle(GAP);
    expect_pix("restart_pix", 0, {2'd0, 24'h112233});

    // Five pixels into a four-LED frame.
    snap();
    for (int i = 0; i < 4; i++) begin
      px = {8'(16 * i), 8'h77, 8'(i)};
      send_pixel(px);
    end
    check("ovf_before", overflow, 0);
    send_pixel(24'hDEAD42);
    idle(10);
    check("ovf_after", overflow, 1);
    check("ovf_data_hold", {address, green, red, blue}, {2'd3, 8'd48, 8'h77, 8'd3});
    idle(GAP);
    check("ovf_cleared", overflow, 0);
    expect_counts("ovf", 4, 1, 0);

    // Partial pixel (12 bits) then a latch gap.
    snap();
    part = 12'hABC;
    for (int i = 11; i >= 0; i--) send_bit(part[i]);
    idle(2480);
    expect_counts("partial", 0, 0, 1);
    snap();
    send_pixel(24'h123456);
    idle(GAP);
    expect_pix("partial_next", 0, {2'd0, 24'h123456});

    // Width boundaries: 22 high -> 0, 23 high -> 1.
    snap();
    px = 24'h5AC396;
    pulse(22, 40);
    pulse(23, 39);
    for (int i = 21; i >= 0; i--) send_bit(px[i]);
    idle(GAP);
    expect_pix("thresh_pix", 0, {2'd0, 24'h5AC396});
    expect_counts("thresh", 1, 1, 0);

    // Too-short pulse: error, pulses ignored until a full low gap.
    snap();
    pulse(2, 60);
    check("short_err", n_err - b_err, 1);
    send_pixel(24'hFFFFFF);
    idle(GAP);
    expect_counts("short_sync", 0, 0, 1);
    snap();
    send_pixel(24'h0F1E2D);
    idle(GAP);
    expect_pix("short_next", 0, {2'd0, 24'h0F1E2D});

    // Over-long pulse behaves the same way.
    snap();
    pulse(124, 40);
    check("long_err", n_err - b_err, 1);
    send_pixel(24'hFFFFFF);
    idle(GAP);
    expect_counts("long_sync", 0, 0, 1);
    snap();
    send_pixel(24'h778899);
    idle(GAP);
    expect_pix("long_next", 0, {2'd0, 24'h778899});

    // Asynchronous reset in the middle of bit 10.
    px = 24'hF0F0F0;
    for (int i = 23; i > 13; i--) send_bit(px[i]);
    DI = 1'b1;
    repeat (10) @(posedge clk);
    check("mid_in_frame", in_frame, 1);
    #5;
    reset_n = 1'b0;
    DI      = 1'b0;
    #2;
    check("mid_reset_outputs",
          {pixel_valid, address, red, green, blue, frame_done, bit_error, overflow, in_frame}, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    snap();
    send_pixel(24'hAAAAAA);
    idle(GAP);
    expect_counts("post_reset_sync", 0, 0, 0);
    snap();
    send_pixel(24'hC0FFEE);
    idle(GAP);
    expect_pix("post_reset_pix", 0, {2'd0, 24'hC0FFEE});
    expect_counts("post_reset", 1, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
